// File: rtl/fighter_pkg.sv
`default_nettype none
// ============================================================================
// Module : fighter_pkg
// Brief  : Shared fighter types (animation state, hit kind) and frame timings.
// Rev    : 1.0  initial release
// ============================================================================
package fighter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WALK    = 4'd1,
        ST_CROUCH  = 4'd2,
        ST_PUNCH   = 4'd3,
        ST_KICK    = 4'd4,
        ST_CPUNCH  = 4'd5,
        ST_JUMP    = 4'd6,
        ST_SPECIAL = 4'd7,
        ST_HITSTUN = 4'd8,
        ST_KO      = 4'd9,
        ST_KO_HOLD = 4'd10
    } fsm_state_t;

    typedef enum logic [1:0] {
        HK_PUNCH  = 2'd0,
        HK_KICK   = 2'd1,
        HK_CPUNCH = 2'd2
    } hit_kind_t;

    localparam int DEF_PHASE_FRAMES = 8;
    localparam int DEF_ATK_FRAMES   = 15;
    localparam int DEF_HIT_FRAME    = 4;
    localparam int DEF_BUF_FRAMES   = 5;
    localparam int DEF_JUMP_FRAMES  = 45;
    localparam int DEF_SPEC_FRAMES  = 45;
    localparam int DEF_SPAWN_FRAME  = 44;
    localparam int DEF_STUN_FRAMES  = 12;
    localparam int DEF_KO_FRAMES    = 10;

    function automatic logic is_busy(input fsm_state_t s);
        return !(s inside {ST_IDLE, ST_WALK, ST_CROUCH});
    endfunction

    function automatic logic is_attack(input fsm_state_t s);
        return s inside {ST_PUNCH, ST_KICK, ST_CPUNCH};
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_det.sv
`default_nettype none
// ============================================================================
// Module : frame_tick_det
// Brief  : Rising-edge detector turning the vsync-rate frame_clk into a tick.
// Rev    : 1.0  initial release
// ============================================================================
module frame_tick_det (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic r_frame_clk_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_clk_q <= 1'b0;
        end else begin
            r_frame_clk_q <= frame_clk;
        end
    end

    assign tick = frame_clk & ~r_frame_clk_q;

endmodule
`default_nettype wire

// File: rtl/fighter_action_seq.sv
`default_nettype none
// ============================================================================
// Module : fighter_action_seq
// Brief  : Per-player action sequencer: buttons -> animation state, phase,
//          frame counter, attack pulses, projectile spawn and special meter.
// Rev    : 1.0  initial release
// ============================================================================
module fighter_action_seq
    import fighter_pkg::*;
#(
    parameter int PHASE_FRAMES = DEF_PHASE_FRAMES,
    parameter int ATK_FRAMES   = DEF_ATK_FRAMES,
    parameter int HIT_FRAME    = DEF_HIT_FRAME,
    parameter int BUF_FRAMES   = DEF_BUF_FRAMES,
    parameter int JUMP_FRAMES  = DEF_JUMP_FRAMES,
    parameter int SPEC_FRAMES  = DEF_SPEC_FRAMES,
    parameter int SPAWN_FRAME  = DEF_SPAWN_FRAME,
    parameter int STUN_FRAMES  = DEF_STUN_FRAMES,
    parameter int KO_FRAMES    = DEF_KO_FRAMES,
    parameter int METER_W      = 10,
    parameter int METER_MAX    = 200,
    parameter int METER_GAIN   = 20
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_fwd,
    input  logic               btn_back,
    input  logic               btn_punch,
    input  logic               btn_kick,
    input  logic               btn_spec,
    input  logic               is_dead,
    input  logic               got_hit,
    input  logic               hit_landed,
    output logic [3:0]         anim_state,
    output logic [1:0]         anim_phase,
    output logic [7:0]         frame_cnt,
    output logic               hit_pulse,
    output logic [1:0]         hit_kind,
    output logic               proj_spawn,
    output logic [METER_W-1:0] meter,
    output logic               busy
);

    localparam logic [7:0] c_ATK_END      = 8'(ATK_FRAMES - 1);
    localparam logic [7:0] c_BUF_START    = 8'(ATK_FRAMES - BUF_FRAMES);
    localparam logic [7:0] c_HIT_FRAME    = 8'(HIT_FRAME);
    localparam logic [7:0] c_HIT_FRAME2   = 8'(2 * HIT_FRAME);
    localparam logic [7:0] c_JUMP_END     = 8'(JUMP_FRAMES - 1);
    localparam logic [7:0] c_SPEC_END     = 8'(SPEC_FRAMES - 1);
    localparam logic [7:0] c_STUN_END     = 8'(STUN_FRAMES - 1);
    localparam logic [7:0] c_KO_END       = 8'(KO_FRAMES - 1);
    localparam logic [7:0] c_SPAWN_FRAME  = 8'(SPAWN_FRAME);
    localparam logic [7:0] c_PHASE_FRAMES = 8'(PHASE_FRAMES);
    localparam logic [7:0] c_FRAME_SAT    = 8'hFF;

    localparam logic [METER_W-1:0] c_METER_MAX      = METER_W'(METER_MAX);
    localparam logic [METER_W-1:0] c_METER_GAIN     = METER_W'(METER_GAIN);
    localparam logic [METER_W-1:0] c_METER_HEADROOM = METER_W'(METER_MAX - METER_GAIN);

    logic w_tick;

    fsm_state_t         r_state_q,     w_state_d;
    logic [7:0]         r_frame_q,     w_frame_d;
    logic [1:0]         r_phase_q,     w_phase_d;
    logic               r_busy_q,      w_busy_d;
    logic               r_hit_pulse_q, w_hit_pulse_d;
    hit_kind_t          r_hit_kind_q,  w_hit_kind_d;
    logic               r_spawn_q,     w_spawn_d;
    logic               r_buf_valid_q, w_buf_valid_d;
    fsm_state_t         r_buf_kind_q,  w_buf_kind_d;
    logic               r_hit_latch_q, w_hit_latch_d;
    logic [METER_W-1:0] r_meter_q;

    logic       w_got_hit;
    logic       w_press;
    fsm_state_t w_press_state;
    logic       w_in_window;
    logic       w_restart;
    logic       w_changed;
    logic       w_special_entry;
    logic [7:0] w_phase_quot;

    frame_tick_det u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (w_tick)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_restart     = 1'b0;
        w_got_hit     = got_hit | r_hit_latch_q;
        w_press       = btn_punch | btn_kick;
        w_press_state = btn_kick ? ST_KICK : ST_PUNCH;
        w_in_window   = (r_frame_q >= c_BUF_START);

        if (is_dead && !(r_state_q inside {ST_KO, ST_KO_HOLD})) begin
            w_state_d = ST_KO;
        end else if (w_got_hit && !(r_state_q inside {ST_JUMP, ST_SPECIAL, ST_KO, ST_KO_HOLD})) begin
            w_state_d = ST_HITSTUN;
        end else begin
            case (r_state_q)
                ST_IDLE, ST_WALK: begin
                    if (btn_up)                                  w_state_d = ST_JUMP;
                    else if (btn_down)                           w_state_d = ST_CROUCH;
                    else if (btn_kick)                           w_state_d = ST_KICK;
                    else if (btn_punch)                          w_state_d = ST_PUNCH;
                    else if (btn_spec && r_meter_q == c_METER_MAX) w_state_d = ST_SPECIAL;
                    else if (btn_fwd || btn_back)                w_state_d = ST_WALK;
                    else                                         w_state_d = ST_IDLE;
                end
                ST_CROUCH: begin
                    if (btn_punch)      w_state_d = ST_CPUNCH;
                    else if (!btn_down) w_state_d = ST_IDLE;
                end
                ST_CPUNCH: begin
                    if (r_frame_q == c_ATK_END) w_state_d = btn_down ? ST_CROUCH : ST_IDLE;
                end
                ST_PUNCH, ST_KICK: begin
                    // A press on the final frame itself still counts as buffered.
                    if (r_frame_q == c_ATK_END) begin
                        if (w_press) begin
                            w_state_d = w_press_state;
                            w_restart = 1'b1;
                        end else if (r_buf_valid_q) begin
                            w_state_d = r_buf_kind_q;
                            w_restart = 1'b1;
                        end else begin
                            w_state_d = ST_IDLE;
                        end
                    end
                end
                ST_JUMP:    if (r_frame_q == c_JUMP_END) w_state_d = ST_IDLE;
                ST_SPECIAL: if (r_frame_q == c_SPEC_END) w_state_d = ST_IDLE;
                ST_HITSTUN: if (r_frame_q == c_STUN_END) w_state_d = ST_IDLE;
                ST_KO:      if (r_frame_q == c_KO_END)   w_state_d = ST_KO_HOLD;
                ST_KO_HOLD: if (!is_dead)                w_state_d = ST_IDLE;
                default:    w_state_d = ST_IDLE;
            endcase
        end

        w_changed = (w_state_d != r_state_q) || w_restart;

        if (w_changed)                    w_frame_d = 8'd0;
        else if (r_frame_q == c_FRAME_SAT) w_frame_d = c_FRAME_SAT;
        else                              w_frame_d = r_frame_q + 8'd1;

        w_buf_valid_d = r_buf_valid_q;
        w_buf_kind_d  = r_buf_kind_q;
        if (w_changed) begin
            w_buf_valid_d = 1'b0;
        end else if ((r_state_q inside {ST_PUNCH, ST_KICK}) && w_in_window && w_press) begin
            w_buf_valid_d = 1'b1;
            w_buf_kind_d  = w_press_state;
        end

        w_phase_quot = w_frame_d / c_PHASE_FRAMES;
        if (w_state_d inside {ST_IDLE, ST_WALK})  w_phase_d = 2'(w_phase_quot % 8'd3);
        else if (is_attack(w_state_d)) begin
            if (w_frame_d < c_HIT_FRAME)       w_phase_d = 2'd0;
            else if (w_frame_d < c_HIT_FRAME2) w_phase_d = 2'd1;
            else                               w_phase_d = 2'd2;
        end else                               w_phase_d = 2'd0;

        w_busy_d      = is_busy(w_state_d);
        w_hit_pulse_d = w_tick && is_attack(w_state_d) && (w_frame_d == c_HIT_FRAME);
        w_hit_kind_d  = HK_PUNCH;
        if (w_hit_pulse_d) begin
            case (w_state_d)
                ST_KICK:   w_hit_kind_d = HK_KICK;
                ST_CPUNCH: w_hit_kind_d = HK_CPUNCH;
                default:   w_hit_kind_d = HK_PUNCH;
            endcase
        end
        w_spawn_d       = w_tick && (w_state_d == ST_SPECIAL) && (w_frame_d == c_SPAWN_FRAME);
        w_special_entry = w_tick && (w_state_d == ST_SPECIAL) && (r_state_q != ST_SPECIAL);
        w_hit_latch_d   = w_tick ? 1'b0 : (r_hit_latch_q | got_hit);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q     <= ST_IDLE;
            r_frame_q     <= 8'd0;
            r_phase_q     <= 2'd0;
            r_busy_q      <= 1'b0;
            r_hit_pulse_q <= 1'b0;
            r_hit_kind_q  <= HK_PUNCH;
            r_spawn_q     <= 1'b0;
            r_buf_valid_q <= 1'b0;
            r_buf_kind_q  <= ST_PUNCH;
            r_hit_latch_q <= 1'b0;
        end else begin
            r_hit_pulse_q <= w_hit_pulse_d;
            r_hit_kind_q  <= w_hit_kind_d;
            r_spawn_q     <= w_spawn_d;
            r_hit_latch_q <= w_hit_latch_d;
            if (w_tick) begin
                r_state_q     <= w_state_d;
                r_frame_q     <= w_frame_d;
                r_phase_q     <= w_phase_d;
                r_busy_q      <= w_busy_d;
                r_buf_valid_q <= w_buf_valid_d;
                r_buf_kind_q  <= w_buf_kind_d;
            end
        end
    end

    // Entering SPECIAL spends the meter, even against a same-cycle gain.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_meter_q <= '0;
        end else if (w_special_entry) begin
            r_meter_q <= '0;
        end else if (hit_landed) begin
            r_meter_q <= (r_meter_q >= c_METER_HEADROOM) ? c_METER_MAX : r_meter_q + c_METER_GAIN;
        end
    end

    assign anim_state = r_state_q;
    assign anim_phase = r_phase_q;
    assign frame_cnt  = r_frame_q;
    assign hit_pulse  = r_hit_pulse_q;
    assign hit_kind   = r_hit_kind_q;
    assign proj_spawn = r_spawn_q;
    assign meter      = r_meter_q;
    assign busy       = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fighter_action_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_fighter_action_seq
// Brief  : Scoreboard bench for fighter_action_seq with a frame-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fighter_action_seq;

    localparam int IDLE = 0, WALK = 1, CROUCH = 2, PUNCH = 3, KICK = 4, CPUNCH = 5;
    localparam int JUMP = 6, SPECIAL = 7, HITSTUN = 8, KO = 9, KO_HOLD = 10;
    localparam int ATK = 15, HITF = 4, BUFF = 5, JUMPF = 45, SPECF = 45, SPAWNF = 44;
    localparam int STUNF = 12, KOF = 10, PHASEF = 8, MMAX = 200, MGAIN = 20;

    localparam logic [6:0] B_NONE  = 7'b0000000;
    localparam logic [6:0] B_UP    = 7'b1000000;
    localparam logic [6:0] B_FWD   = 7'b0010000;
    localparam logic [6:0] B_PUNCH = 7'b0000100;
    localparam logic [6:0] B_KICK  = 7'b0000010;
    localparam logic [6:0] B_SPEC  = 7'b0000001;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk;
    logic       btn_up, btn_down, btn_fwd, btn_back, btn_punch, btn_kick, btn_spec;
    logic       is_dead, got_hit, hit_landed;
    logic [3:0] anim_state;
    logic [1:0] anim_phase;
    logic [7:0] frame_cnt;
    logic       hit_pulse;
    logic [1:0] hit_kind;
    logic       proj_spawn;
    logic [9:0] meter;
    logic       busy;

    fighter_action_seq dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .btn_up(btn_up), .btn_down(btn_down), .btn_fwd(btn_fwd), .btn_back(btn_back),
        .btn_punch(btn_punch), .btn_kick(btn_kick), .btn_spec(btn_spec),
        .is_dead(is_dead), .got_hit(got_hit), .hit_landed(hit_landed),
        .anim_state(anim_state), .anim_phase(anim_phase), .frame_cnt(frame_cnt),
        .hit_pulse(hit_pulse), .hit_kind(hit_kind), .proj_spawn(proj_spawn),
        .meter(meter), .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int st; int fc; int ph; int busy; int meter; int hp; int hk; int sp;
    } exp_t;
    exp_t exp_q[$];

    int m_st, m_fc, m_meter, m_buf;
    bit m_hit_pend;
    int n_pass = 0, n_checks = 0;
    bit done = 1'b0;

    function automatic int gain(input int m);
        return (m + MGAIN > MMAX) ? MMAX : m + MGAIN;
    endfunction

    task automatic model_reset();
        m_st = IDLE; m_fc = 0; m_meter = 0; m_buf = -1; m_hit_pend = 1'b0;
    endtask

    // Frame-level reference: one call per frame tick, rules taken straight from the behaviour list.
    task automatic model_tick(input logic [6:0] b, input logic dead, input logic hit_now, input logic land_now);
        logic up, down, fwd, back, pu, ki, sp;
        int   ns, pk;
        bit   restart, hit, press, in_win, attack;
        exp_t e;
        {up, down, fwd, back, pu, ki, sp} = b;
        ns = m_st; restart = 0;
        hit = m_hit_pend | hit_now;
        press = pu | ki;
        pk = ki ? KICK : PUNCH;
        in_win = (m_fc >= ATK - BUFF);
        if (dead && m_st != KO && m_st != KO_HOLD) ns = KO;
        else if (hit && m_st != JUMP && m_st != SPECIAL && m_st != KO && m_st != KO_HOLD) ns = HITSTUN;
        else if (m_st == IDLE || m_st == WALK) begin
            if (up) ns = JUMP;
            else if (down) ns = CROUCH;
            else if (ki) ns = KICK;
            else if (pu) ns = PUNCH;
            else if (sp && m_meter == MMAX) ns = SPECIAL;
            else if (fwd || back) ns = WALK;
            else ns = IDLE;
        end else if (m_st == CROUCH) begin
            if (pu) ns = CPUNCH; else if (!down) ns = IDLE;
        end else if (m_st == CPUNCH) begin
            if (m_fc == ATK - 1) ns = down ? CROUCH : IDLE;
        end else if (m_st == PUNCH || m_st == KICK) begin
            if (m_fc == ATK - 1) begin
                if (press) begin ns = pk; restart = 1; end
                else if (m_buf >= 0) begin ns = m_buf; restart = 1; end
                else ns = IDLE;
            end
        end else if (m_st == JUMP) begin
            if (m_fc == JUMPF - 1) ns = IDLE;
        end else if (m_st == SPECIAL) begin
            if (m_fc == SPECF - 1) ns = IDLE;
        end else if (m_st == HITSTUN) begin
            if (m_fc == STUNF - 1) ns = IDLE;
        end else if (m_st == KO) begin
            if (m_fc == KOF - 1) ns = KO_HOLD;
        end else if (m_st == KO_HOLD) begin
            if (!dead) ns = IDLE;
        end

        if (ns == SPECIAL && m_st != SPECIAL) m_meter = 0;
        else if (land_now) m_meter = gain(m_meter);

        if (ns != m_st || restart) m_buf = -1;
        else if ((m_st == PUNCH || m_st == KICK) && in_win && press) m_buf = pk;

        if (ns != m_st || restart) m_fc = 0;
        else if (m_fc < 255) m_fc = m_fc + 1;
        m_st = ns;
        m_hit_pend = 1'b0;

        attack = (ns == PUNCH || ns == KICK || ns == CPUNCH);
        e.st = ns; e.fc = m_fc; e.meter = m_meter;
        if (ns == IDLE || ns == WALK) e.ph = (m_fc / PHASEF) % 3;
        else if (attack) e.ph = (m_fc < HITF) ? 0 : (m_fc < 2 * HITF) ? 1 : 2;
        else e.ph = 0;
        e.busy = (ns == IDLE || ns == WALK || ns == CROUCH) ? 0 : 1;
        e.hp = (attack && m_fc == HITF) ? 1 : 0;
        e.hk = (ns == PUNCH) ? 0 : (ns == KICK) ? 1 : 2;
        e.sp = (ns == SPECIAL && m_fc == SPAWNF) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Frame: two quiet cycles (optional got_hit / hit_landed pulses), then a tick cycle.
    task automatic do_frame(input logic [6:0] b, input logic dead, input logic hg, input logic ht,
                            input logic lg, input logic lt);
        {btn_up, btn_down, btn_fwd, btn_back, btn_punch, btn_kick, btn_spec} = b;
        is_dead = dead;
        @(negedge Clk);
        if (hg) begin got_hit = 1'b1; m_hit_pend = 1'b1; end
        if (lg) begin hit_landed = 1'b1; m_meter = gain(m_meter); end
        @(negedge Clk);
        got_hit = 1'b0; hit_landed = 1'b0;
        @(negedge Clk);
        model_tick(b, dead, ht, lt);
        frame_clk = 1'b1; got_hit = ht; hit_landed = lt;
        @(negedge Clk);
        got_hit = 1'b0; hit_landed = 1'b0;
        @(negedge Clk);
        frame_clk = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) do_frame(B_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        Reset = 1'b1; frame_clk = 1'b0; got_hit = 1'b0; hit_landed = 1'b0; is_dead = 1'b0;
        {btn_up, btn_down, btn_fwd, btn_back, btn_punch, btn_kick, btn_spec} = B_NONE;
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a frame tick has updated the DUT.
    logic prev_fc = 1'b0, upd = 1'b0, rst_seen = 1'b0, final_done = 1'b0;
    always @(posedge Clk) begin
        upd      <= !Reset && frame_clk && !prev_fc;
        prev_fc  <= Reset ? 1'b0 : frame_clk;
        rst_seen <= Reset;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    endtask

    exp_t me;
    always @(negedge Clk) begin
        if (rst_seen) begin
            chk("reset_state", int'(anim_state), IDLE);
            chk("reset_phase", int'(anim_phase), 0);
            chk("reset_frame", int'(frame_cnt), 0);
            chk("reset_meter", int'(meter), 0);
            chk("reset_pulses", int'({hit_pulse, proj_spawn, busy}), 0);
            chk("reset_kind", int'(hit_kind), 0);
        end else if (upd) begin
            if (exp_q.size() == 0) chk("queue_underflow", 1, 0);
            else begin
                me = exp_q.pop_front();
                chk("anim_state", int'(anim_state), me.st);
                chk("frame_cnt", int'(frame_cnt), me.fc);
                chk("anim_phase", int'(anim_phase), me.ph);
                chk("busy", int'(busy), me.busy);
                chk("meter", int'(meter), me.meter);
                chk("hit_pulse", int'(hit_pulse), me.hp);
                if (me.hp != 0) chk("hit_kind", int'(hit_kind), me.hk);
                chk("proj_spawn", int'(proj_spawn), me.sp);
            end
        end else begin
            chk("pulse_quiet", int'({hit_pulse, proj_spawn}), 0);
        end
        if (done && !final_done) begin
            chk("queue_drained", exp_q.size(), 0);
            final_done <= 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [6:0] rb;
    logic       r_dead;
    initial begin
        do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        idle(260);                                           // phase wrap and frame saturation
        do_frame(B_PUNCH, 0, 0, 0, 0, 0); idle(16);          // single punch
        do_frame(B_PUNCH, 0, 0, 0, 0, 0); idle(11);          // kick at frame 11 chains
        do_frame(B_KICK, 0, 0, 0, 0, 0);  idle(22);
        do_frame(B_PUNCH, 0, 0, 0, 0, 0); idle(9);           // kick at frame 9 ignored
        do_frame(B_KICK, 0, 0, 0, 0, 0);  idle(10);
        repeat (11) do_frame(B_NONE, 0, 0, 0, 1, 0);         // meter fill and saturation
        do_frame(B_SPEC, 0, 0, 0, 0, 1);  idle(50);          // special, same-cycle gain loses
        repeat (3) do_frame(B_FWD, 0, 0, 0, 0, 0);
        do_frame(B_FWD, 0, 1, 0, 0, 0);   idle(14);          // hitstun from walk
        do_frame(B_UP, 0, 0, 0, 0, 0); idle(3);
        do_frame(B_NONE, 0, 1, 0, 0, 0); do_frame(B_NONE, 0, 0, 1, 0, 0); idle(45);
        do_frame(B_KICK, 0, 0, 0, 0, 0);  idle(2);           // KO at kick frame 2
        repeat (12) do_frame(B_NONE, 1, 0, 0, 0, 0);
        idle(2);
        repeat (3) do_frame(B_NONE, 1, 0, 0, 0, 0);
        do_reset();                                          // reset mid-KO
        idle(2);

        r_dead = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 7; k++) rb[k] = ($urandom_range(5) == 0);
            if (!r_dead) r_dead = ($urandom_range(59) == 0);
            else         r_dead = !($urandom_range(7) == 0);
            do_frame(rb, r_dead, $urandom_range(14) == 0, $urandom_range(29) == 0,
                     $urandom_range(3) == 0, $urandom_range(9) == 0);
        end

        done = 1'b1;
        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
